// File: rtl/sound_ram_arbiter_if.sv
// Sound RAM arbiter bus: DOC fetch port, GLU host port and syncram side.
// The arbiter uses the slave modport; requesters and RAM use master.
interface sound_ram_arbiter_if #(
  parameter int ADDR_W = 16
) ();
  logic              doc_req;
  logic [ADDR_W-1:0] doc_addr;
  logic [7:0]        doc_data;
  logic              doc_valid;
  logic              doc_overrun;
  logic              host_req;
  logic              host_wr;
  logic [ADDR_W-1:0] host_addr;
  logic [7:0]        host_wdata;
  logic [7:0]        host_rdata;
  logic              host_ack;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [7:0]        ram_wdata;
  logic [7:0]        ram_rdata;

  modport slave (
    input  doc_req, doc_addr,
    output doc_data, doc_valid, doc_overrun,
    input  host_req, host_wr, host_addr, host_wdata,
    output host_rdata, host_ack,
    output ram_addr, ram_we, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output doc_req, doc_addr,
    input  doc_data, doc_valid, doc_overrun,
    output host_req, host_wr, host_addr, host_wdata,
    input  host_rdata, host_ack,
    input  ram_addr, ram_we, ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/sound_ram_arbiter.sv
// DOC-priority sound RAM scheduler with host anti-starvation limit.
// Optional SOUND_ARB_STATS_EN adds grant/stall counters.
module sound_ram_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  sound_ram_arbiter_if.slave bus
`ifdef SOUND_ARB_STATS_EN
  ,
  output logic [15:0] doc_grants,
  output logic [15:0] host_grants,
  output logic [15:0] host_stall
`endif
);

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  typedef enum logic [2:0] {
    IDLE, DOC_RD, DOC_CAP, HST_RD, HST_CAP, HST_WR
  } state_t;

  state_t            state_q, state_d;
  logic              doc_pend_q, doc_pend_d;
  logic [ADDR_W-1:0] doc_addr_q, doc_addr_d;
  logic              doc_ovr_q, doc_ovr_d;
  logic [3:0]        starve_q, starve_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              ram_we_q, ram_we_d;
  logic [7:0]        ram_wdata_q, ram_wdata_d;
  logic [7:0]        doc_data_q, doc_data_d;
  logic              doc_valid_q, doc_valid_d;
  logic [7:0]        host_rdata_q, host_rdata_d;
  logic              host_ack_q, host_ack_d;

  logic              doc_any, host_rdy;
  logic              doc_gnt, host_gnt;
  logic [ADDR_W-1:0] doc_ga;

  assign doc_any  = doc_pend_q | bus.doc_req;
  assign doc_ga   = doc_pend_q ? doc_addr_q : bus.doc_addr;
  assign host_rdy = bus.host_req & ~host_ack_q;

  // Host only overtakes a pending DOC fetch once the starve limit is hit.
  always_comb begin
    doc_gnt  = 1'b0;
    host_gnt = 1'b0;
    if (state_q == IDLE) begin
      if (doc_any && (starve_q < SMAX || !host_rdy))
        doc_gnt = 1'b1;
      else if (host_rdy)
        host_gnt = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    doc_pend_d   = doc_pend_q;
    doc_addr_d   = doc_addr_q;
    doc_ovr_d    = doc_ovr_q;
    starve_d     = starve_q;
    ram_addr_d   = ram_addr_q;
    ram_we_d     = 1'b0;
    ram_wdata_d  = ram_wdata_q;
    doc_data_d   = doc_data_q;
    doc_valid_d  = 1'b0;
    host_rdata_d = host_rdata_q;
    host_ack_d   = 1'b0;

    if (bus.doc_req) begin
      if (doc_pend_q) begin
        doc_ovr_d = 1'b1;
      end else begin
        doc_pend_d = 1'b1;
        doc_addr_d = bus.doc_addr;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (doc_gnt) begin
          state_d    = DOC_RD;
          ram_addr_d = doc_ga;
          if (bus.host_req && starve_q < SMAX)
            starve_d = starve_q + 4'd1;
        end else if (host_gnt) begin
          starve_d   = '0;
          ram_addr_d = bus.host_addr;
          if (bus.host_wr) begin
            state_d     = HST_WR;
            ram_we_d    = 1'b1;
            ram_wdata_d = bus.host_wdata;
          end else begin
            state_d = HST_RD;
          end
        end
      end
      DOC_RD: begin
        doc_pend_d = 1'b0;
        state_d    = DOC_CAP;
      end
      DOC_CAP: begin
        doc_data_d  = bus.ram_rdata;
        doc_valid_d = 1'b1;
        state_d     = IDLE;
      end
      HST_RD: state_d = HST_CAP;
      HST_CAP: begin
        host_rdata_d = bus.ram_rdata;
        host_ack_d   = 1'b1;
        state_d      = IDLE;
      end
      HST_WR: begin
        host_ack_d = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      doc_pend_q   <= 1'b0;
      doc_addr_q   <= '0;
      doc_ovr_q    <= 1'b0;
      starve_q     <= '0;
      ram_addr_q   <= '0;
      ram_we_q     <= 1'b0;
      ram_wdata_q  <= '0;
      doc_data_q   <= '0;
      doc_valid_q  <= 1'b0;
      host_rdata_q <= '0;
      host_ack_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      doc_pend_q   <= doc_pend_d;
      doc_addr_q   <= doc_addr_d;
      doc_ovr_q    <= doc_ovr_d;
      starve_q     <= starve_d;
      ram_addr_q   <= ram_addr_d;
      ram_we_q     <= ram_we_d;
      ram_wdata_q  <= ram_wdata_d;
      doc_data_q   <= doc_data_d;
      doc_valid_q  <= doc_valid_d;
      host_rdata_q <= host_rdata_d;
      host_ack_q   <= host_ack_d;
    end
  end

  assign bus.doc_data    = doc_data_q;
  assign bus.doc_valid   = doc_valid_q;
  assign bus.doc_overrun = doc_ovr_q;
  assign bus.host_rdata  = host_rdata_q;
  assign bus.host_ack    = host_ack_q;
  assign bus.ram_addr    = ram_addr_q;
  assign bus.ram_we      = ram_we_q;
  assign bus.ram_wdata   = ram_wdata_q;

`ifdef SOUND_ARB_STATS_EN
  logic [15:0] doc_grants_q, host_grants_q, host_stall_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      doc_grants_q  <= '0;
      host_grants_q <= '0;
      host_stall_q  <= '0;
    end else begin
      if (doc_gnt)
        doc_grants_q <= doc_grants_q + 16'd1;
      if (host_gnt)
        host_grants_q <= host_grants_q + 16'd1;
      if (host_rdy && !host_gnt)
        host_stall_q <= host_stall_q + 16'd1;
    end
  end

  assign doc_grants  = doc_grants_q;
  assign host_grants = host_grants_q;
  assign host_stall  = host_stall_q;
`endif

endmodule
